coproc_cmd_issuer: RTL

Host-side initiator for the image coprocessor's command interface. It drives INSTRUCTION, MEM_ADDR, DATA_IN and ENABLE, and retires each command on FLAG_DONE.
- Commands are buffered in an internal FIFO and issued one at a time using a return-to-zero ENABLE/DONE handshake.
- DATA_OUT is captured for LOAD commands.
- Sits between the HPS/PIO bridge and the coprocessor top level.

---
 rtl/coproc_cmd_issuer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/coproc_cmd_issuer.sv
// coproc_cmd_issuer
//   Host-side initiator for the image coprocessor command interface. Host
//   commands are queued in a small FIFO and issued one at a time using a
//   return-to-zero ENABLE/DONE handshake. DATA_OUT is captured for LOADs.
//
// Ports
//   clock, reset                      clock / async active-high reset
//   cmd_valid/ready/instr/addr/data   host command push (FIFO input)
//   rsp_valid/ready/instr/data/error  retired-command response
//   co_instruction/mem_addr/data_in   coprocessor buses (held while enable=1)
//   co_enable                         coprocessor ENABLE
//   co_data_out, co_flag_done         coprocessor DATA_OUT / FLAG_DONE (async)
//   busy                              FSM active or FIFO non-empty
//   fifo_count                        FIFO occupancy
//
// Optional feature macro: ISSUER_TIMEOUT_EN
//   Defined: a command waiting longer than TIMEOUT_CYCLES in WAIT_DONE/RELEASE
//   is abandoned and answered with rsp_error=1. Undefined: waits forever.
module coproc_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_instr,
    input  logic [17:0]                  cmd_addr,
    input  logic [7:0]                   cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2:0]                   rsp_instr,
    output logic [7:0]                   rsp_data,
    output logic                         rsp_error,
    output logic [2:0]                   co_instruction,
    output logic [17:0]                  co_mem_addr,
    output logic [7:0]                   co_data_in,
    output logic                         co_enable,
    input  logic [7:0]                   co_data_out,
    input  logic                         co_flag_done,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT_DONE, RELEASE, RESPOND} state_t;
    state_t state;

    // ---------------- done synchronizer ----------------
    logic done_meta, done_s;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= co_flag_done;
            done_s    <= done_meta;
        end
    end

    // ---------------- command FIFO ----------------
    logic [28:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [2:0]    head_instr;
    logic [17:0]   head_addr;
    logic [7:0]    head_data;

    assign cmd_ready = (fifo_count != (PW+1)'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // A stale done (still high from the previous handshake) blocks the pop so
    // the coprocessor always sees a clean rising ENABLE.
    assign pop       = (state == IDLE) && (fifo_count != '0) && !done_s && !rsp_valid;
    assign {head_instr, head_addr, head_data} = mem[rd_ptr];
    assign busy      = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {cmd_instr, cmd_addr, cmd_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- optional timeout ----------------
    logic to_hit;
`ifdef ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          waiting;
    assign waiting = (state == WAIT_DONE) || (state == RELEASE);
    assign to_hit  = waiting && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 to_cnt <= '0;
        else if (pop)              to_cnt <= '0;   // cleared whenever a command enters SETUP
        else if (waiting && !to_hit) to_cnt <= to_cnt + TW'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    // ---------------- issue FSM ----------------
    logic [SW-1:0] setup_cnt;
    logic          setup_done;
    assign setup_done = (int'(setup_cnt) + 1 >= SETUP_CYCLES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            setup_cnt      <= '0;
            co_instruction <= '0;
            co_mem_addr    <= '0;
            co_data_in     <= '0;
            co_enable      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_instr      <= '0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_instr == OP_NOP) begin
                            // NOP never touches the coprocessor
                            rsp_valid <= 1'b1;
                            rsp_instr <= OP_NOP;
                            rsp_data  <= '0;
                            rsp_error <= 1'b0;
                            state     <= RESPOND;
                        end else begin
                            co_instruction <= head_instr;
                            co_mem_addr    <= head_addr;
                            co_data_in     <= head_data;
                            setup_cnt      <= '0;
                            state          <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (setup_done) state     <= ISSUE;
                    else            setup_cnt <= setup_cnt + SW'(1);
                end
                ISSUE: begin
                    co_enable <= 1'b1;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_s) begin
                        rsp_data  <= (co_instruction == OP_LOAD) ? co_data_out : 8'h00;
                        co_enable <= 1'b0;
                        state     <= RELEASE;
                    end else if (to_hit) begin
                        co_enable <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_instr <= co_instruction;
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                RELEASE: begin
                    // hold off the response until DONE has returned to zero
                    if (!done_s) begin
                        rsp_valid <= 1'b1;
                        rsp_instr <= co_instruction;
                        rsp_error <= 1'b0;
                        state     <= RESPOND;
                    end else if (to_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_instr <= co_instruction;
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
